rhs_zcheck_sweep: RTL and testbench
===================================

# rhs_zcheck_sweep

Sequencer that automates impedance checking across the 256-channel RHS headstage array. It walks a programmed channel range and a set of enabled scales, drives `zcheck_global_channel` / `zcheck_scale` and pulses `zcheck_start` into `rhs_256`, then waits for that block's completion pulse before advancing. It sits between the host register file and `rhs_256`, replacing manual per-channel host sequencing. It reports each completed step and any timeouts.

## Interface
- `NUM_CHANNELS`, default 256: global channel count; `last_channel` must be below this.
- `SETTLE_CYCLES`, default 16: cycles that channel/scale are held stable before `zcheck_start` rises (min 1).
- `START_PULSE_CYCLES`, default 40: width of the `zcheck_start` pulse (min 1).
- `TIMEOUT_CYCLES`, default 2000000: maximum wait for `zcheck_done` per step.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `sweep_start`  in  1  level; sampled only in IDLE.
- `sweep_abort`  in  1  level; honoured in every state.
- `first_channel`  in  12  first global channel; latched at start.
- `last_channel`  in  12  last global channel, inclusive; latched at start.
- `scale_mask`  in  4  bit k enables scale k; latched at start.
- `zcheck_done`  in  1  one-cycle completion pulse from `rhs_256`.
- `zcheck_global_channel`  out  12  channel under test (registered).
- `zcheck_scale`  out  2  scale under test (registered).
- `zcheck_start`  out  1  start pulse to `rhs_256`.
- `busy`  out  1  high in every state except IDLE.
- `step_valid`  out  1  one-cycle pulse when a step completes or times out.
- `step_timeout`  out  1  qualifies `step_valid`: 1 means the step timed out.
- `sweep_done`  out  1  one-cycle pulse at normal sweep completion.
- `sweep_aborted`  out  1  one-cycle pulse when an abort is taken.
- `config_error`  out  1  one-cycle pulse when a start is rejected.
- `timeout_count`  out  12  number of timed-out steps in the current or last sweep.

## Operation
- States: IDLE, SETUP, START, WAIT, NEXT, DONE.
- IDLE, `sweep_start`=1 with a valid configuration:
  - Latch `first_channel`, `last_channel` and `scale_mask`.
  - Channel index = first; scale index = lowest set bit of the mask; clear `timeout_count`.
  - Go to SETUP.
- Start is rejected if `first_channel` > `last_channel`, `last_channel` >= `NUM_CHANNELS`, or `scale_mask` == 0.
  - `config_error` pulses for 1 cycle and the block stays in IDLE.
  - A rejected start is not retried while `sweep_start` is held; it must return low first.
- SETUP: drive channel and scale; hold for `SETTLE_CYCLES` cycles, then go to START.
- START: `zcheck_start` = 1 for exactly `START_PULSE_CYCLES` cycles, then go to WAIT.
- WAIT:
  - `zcheck_done` → `step_valid`=1, `step_timeout`=0, go to NEXT.
  - Timeout counter reaches `TIMEOUT_CYCLES` → `step_valid`=1, `step_timeout`=1, `timeout_count`+1 (saturates at 4095), go to NEXT.
  - Both in the same cycle: done wins and the step is not counted as a timeout.
- NEXT (1 cycle):
  - Scale index advances to the next set bit above it in the latched mask, then go to SETUP.
  - If no higher bit is set, scale index returns to the lowest set bit and the channel increments.
  - If the channel was already `last_channel`, go to DONE instead.
  - Order: channel-major, scales ascending within each channel.
- DONE: `sweep_done` pulses for 1 cycle, then IDLE. Channel and scale outputs keep their last values.
- Abort, any non-IDLE state:
  - Next cycle: IDLE, `zcheck_start`=0, `sweep_aborted` pulses for 1 cycle.
  - No `sweep_done` and no `step_valid` for the interrupted step.
- Abort in IDLE has no effect. If abort and start are both high in IDLE, abort wins: no start and no pulse.
- `zcheck_done` outside WAIT is ignored.
- `sweep_start` while busy is ignored.
- Input changes after the start is latched have no effect on the running sweep.

## Timing
- Reset: all outputs are 0, state is IDLE, and all counters are cleared. Reset takes effect immediately, mid-sweep included.
- Start is sampled at edge N:
  - `busy`=1 and channel/scale valid from edge N+1.
  - `zcheck_start` rises at edge N+1+`SETTLE_CYCLES`.
- `step_valid` is asserted in the cycle after `zcheck_done` is sampled.
- Next step's channel/scale update 2 cycles after the `zcheck_done` sample (WAIT → NEXT → SETUP).
- Step overhead excluding the wait: `SETTLE_CYCLES` + `START_PULSE_CYCLES` + 1 cycles.
- The timeout counter starts at WAIT entry and is cleared on every exit from WAIT.
- Arithmetic:
  - Channel increment is 12-bit and never wraps, because `last_channel` < `NUM_CHANNELS`.
  - `first_channel` == `last_channel` is legal and gives a single-channel sweep.

## Test plan
- Small sweep, no timeouts:
  - Stimulus: first=169, last=171, mask=4'b1000; done returned 100 cycles after each `zcheck_start` fall.
  - Required: 3 `step_valid` pulses on channels 169, 170, 171 with scale 3; 1 `sweep_done`; `timeout_count`=0.
- Scale order:
  - Stimulus: first=last=5, mask=4'b1011.
  - Required: steps (5,0), (5,1), (5,3) in that order; `zcheck_start` width exactly 40 cycles each; rise exactly 16 cycles after each channel/scale update.
- Timeout, with `TIMEOUT_CYCLES`=50:
  - Stimulus: first=0, last=1, mask=4'b0001; done never returned.
  - Required: 2 `step_valid` with `step_timeout`=1; `timeout_count`=2; `sweep_done` pulses.
  - Done and timeout in the same cycle: `step_timeout`=0.
- Rejected configurations:
  - Stimulus: first=10, last=9; then last=256; then mask=0.
  - Required: `config_error` pulses once per attempt; `busy` stays 0; outputs unchanged.
- Abort in WAIT:
  - Required: `zcheck_start` low and IDLE next cycle; `sweep_aborted` pulses once; no `sweep_done`.
  - Repeat with abort and start together in IDLE: no activity.
- Reset mid-START:
  - Required: all outputs 0 immediately.
  - After `rstn` release, a new sweep with first=240, last=255 runs to completion with 16 steps.

Source files
------------

// File: rtl/rhs_zcheck_sweep.sv
// Impedance-check sweep sequencer for the RHS headstage array: walks a channel
// range and the enabled scales, handshaking each step with rhs_256.
//
// state | meaning
// IDLE  | waiting for sweep_start; configuration checked here
// SETUP | channel/scale driven, settle timer running
// START | zcheck_start held high for the pulse width
// WAIT  | waiting for zcheck_done or the step timeout
// NEXT  | advance scale, then channel; decide whether the sweep is over
// DONE  | sweep_done pulse, then back to IDLE
module rhs_zcheck_sweep #(
  parameter int NUM_CHANNELS       = 256,
  parameter int SETTLE_CYCLES      = 16,
  parameter int START_PULSE_CYCLES = 40,
  parameter int TIMEOUT_CYCLES     = 2000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sweep_start,
  input  logic        sweep_abort,
  input  logic [11:0] first_channel,
  input  logic [11:0] last_channel,
  input  logic [3:0]  scale_mask,
  input  logic        zcheck_done,
  output logic [11:0] zcheck_global_channel,
  output logic [1:0]  zcheck_scale,
  output logic        zcheck_start,
  output logic        busy,
  output logic        step_valid,
  output logic        step_timeout,
  output logic        sweep_done,
  output logic        sweep_aborted,
  output logic        config_error,
  output logic [11:0] timeout_count
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_WAIT, S_NEXT, S_DONE} state_t;

  localparam logic [12:0] NUM_CH13   = 13'(NUM_CHANNELS);
  localparam logic [31:0] SETTLE_LD  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] PULSE_LD   = 32'(START_PULSE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LD = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] timer;
  logic [11:0] last_q;
  logic [3:0]  mask_q;
  logic        start_blocked;
  logic        cfg_ok;
  logic [2:0]  next_sc;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    lowest_bit = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (m[k]) lowest_bit = 2'(k);
  endfunction

  // {found, index} of the lowest set bit strictly above cur
  function automatic logic [2:0] next_bit(input logic [3:0] m, input logic [1:0] cur);
    next_bit = 3'b000;
    for (int k = 3; k >= 0; k--)
      if (m[k] && (k > int'(cur))) next_bit = {1'b1, 2'(k)};
  endfunction

  assign cfg_ok  = (first_channel <= last_channel) && ({1'b0, last_channel} < NUM_CH13) &&
                   (scale_mask != 4'd0);
  assign next_sc = next_bit(mask_q, zcheck_scale);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                 <= S_IDLE;
      timer                 <= '0;
      last_q                <= '0;
      mask_q                <= '0;
      start_blocked         <= 1'b0;
      zcheck_global_channel <= '0;
      zcheck_scale          <= '0;
      zcheck_start          <= 1'b0;
      busy                  <= 1'b0;
      step_valid            <= 1'b0;
      step_timeout          <= 1'b0;
      sweep_done            <= 1'b0;
      sweep_aborted         <= 1'b0;
      config_error          <= 1'b0;
      timeout_count         <= '0;
    end else begin
      step_valid    <= 1'b0;
      step_timeout  <= 1'b0;
      sweep_done    <= 1'b0;
      sweep_aborted <= 1'b0;
      config_error  <= 1'b0;
      if (!sweep_start) start_blocked <= 1'b0;

      if (state != S_IDLE && sweep_abort) begin
        state         <= S_IDLE;
        busy          <= 1'b0;
        zcheck_start  <= 1'b0;
        sweep_aborted <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            // abort outranks start; a rejected start waits for sweep_start to drop
            if (sweep_start && !sweep_abort && !start_blocked) begin
              if (cfg_ok) begin
                last_q                <= last_channel;
                mask_q                <= scale_mask;
                zcheck_global_channel <= first_channel;
                zcheck_scale          <= lowest_bit(scale_mask);
                timeout_count         <= '0;
                timer                 <= SETTLE_LD;
                busy                  <= 1'b1;
                state                 <= S_SETUP;
              end else begin
                config_error  <= 1'b1;
                start_blocked <= 1'b1;
              end
            end
          end
          S_SETUP: begin
            if (timer == 32'd0) begin
              zcheck_start <= 1'b1;
              timer        <= PULSE_LD;
              state        <= S_START;
            end else begin
              timer <= timer - 32'd1;
            end
          end
          S_START: begin
            if (timer == 32'd0) begin
              zcheck_start <= 1'b0;
              timer        <= TIMEOUT_LD;
              state        <= S_WAIT;
            end else begin
              timer <= timer - 32'd1;
            end
          end
          S_WAIT: begin
            if (zcheck_done) begin
              step_valid <= 1'b1;
              timer      <= '0;
              state      <= S_NEXT;
            end else if (timer == 32'd0) begin
              step_valid   <= 1'b1;
              step_timeout <= 1'b1;
              if (timeout_count != 12'hFFF) timeout_count <= timeout_count + 12'd1;
              state        <= S_NEXT;
            end else begin
              timer <= timer - 32'd1;
            end
          end
          S_NEXT: begin
            if (next_sc[2]) begin
              zcheck_scale <= next_sc[1:0];
              timer        <= SETTLE_LD;
              state        <= S_SETUP;
            end else if (zcheck_global_channel == last_q) begin
              sweep_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              zcheck_global_channel <= zcheck_global_channel + 12'd1;
              zcheck_scale          <= lowest_bit(mask_q);
              timer                 <= SETTLE_LD;
              state                 <= S_SETUP;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rhs_zcheck_sweep.sv
// Scoreboard bench for rhs_zcheck_sweep: expected steps are queued at sweep start
// and popped as step_valid pulses arrive; a second instance covers short timeouts.
module tb_rhs_zcheck_sweep;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sweep_start, sweep_abort, zcheck_done;
  logic [11:0] first_channel, last_channel;
  logic [3:0]  scale_mask;
  logic [11:0] ch, timeout_count;
  logic [1:0]  sc;
  logic        zstart, busy, step_valid, step_timeout, sweep_done, sweep_aborted, config_error;

  logic        to_start, to_abort, to_done;
  logic [11:0] to_first, to_last;
  logic [3:0]  to_mask;
  logic [11:0] to_ch, to_tcount;
  logic [1:0]  to_sc;
  logic        to_zstart, to_busy, to_step_valid, to_step_timeout, to_sweep_done, to_aborted, to_cfgerr;

  always #5 clk = ~clk;

  rhs_zcheck_sweep #(.NUM_CHANNELS(256), .SETTLE_CYCLES(16), .START_PULSE_CYCLES(40),
                     .TIMEOUT_CYCLES(2000000)) dut (
    .clk(clk), .rstn(rstn), .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .first_channel(first_channel), .last_channel(last_channel), .scale_mask(scale_mask),
    .zcheck_done(zcheck_done), .zcheck_global_channel(ch), .zcheck_scale(sc),
    .zcheck_start(zstart), .busy(busy), .step_valid(step_valid), .step_timeout(step_timeout),
    .sweep_done(sweep_done), .sweep_aborted(sweep_aborted), .config_error(config_error),
    .timeout_count(timeout_count));

  rhs_zcheck_sweep #(.NUM_CHANNELS(256), .SETTLE_CYCLES(16), .START_PULSE_CYCLES(40),
                     .TIMEOUT_CYCLES(50)) dut_to (
    .clk(clk), .rstn(rstn), .sweep_start(to_start), .sweep_abort(to_abort),
    .first_channel(to_first), .last_channel(to_last), .scale_mask(to_mask),
    .zcheck_done(to_done), .zcheck_global_channel(to_ch), .zcheck_scale(to_sc),
    .zcheck_start(to_zstart), .busy(to_busy), .step_valid(to_step_valid),
    .step_timeout(to_step_timeout), .sweep_done(to_sweep_done), .sweep_aborted(to_aborted),
    .config_error(to_cfgerr), .timeout_count(to_tcount));

  typedef struct {
    logic [11:0] ch;
    logic [1:0]  sc;
    logic        to;
  } step_t;

  step_t sb_q[$];
  step_t exp_s;
  int vectors = 0, miscompares = 0;
  int n_steps = 0, n_done = 0, n_abort = 0, n_cfgerr = 0, n_timing = 0;
  int cyc = 0, stamp = 0, hi_cnt = 0;
  logic chk_timing = 1'b0;
  logic prev_zstart = 1'b0, prev_busy = 1'b0;
  logic [13:0] prev_cs = '0;

  // responder: returns zcheck_done resp_delay cycles after each zcheck_start fall
  logic resp_en = 1'b0;
  int   resp_delay = 100, resp_cnt = 0;
  logic resp_prev = 1'b0;

  always @(negedge clk) begin
    zcheck_done = 1'b0;
    if (!resp_en) resp_cnt = 0;
    else if (resp_prev && !zstart) resp_cnt = resp_delay;
    else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) zcheck_done = 1'b1;
    end
    resp_prev = zstart;
  end

  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (step_valid) begin
        n_steps++;
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL step_unexpected: got ch=%0d sc=%0d to=%0b, none expected", ch, sc, step_timeout);
        end else begin
          exp_s = sb_q.pop_front();
          if ({ch, sc, step_timeout} !== {exp_s.ch, exp_s.sc, exp_s.to}) begin
            miscompares++;
            $display("FAIL step_order: got ch=%0d sc=%0d to=%0b, want ch=%0d sc=%0d to=%0b",
                     ch, sc, step_timeout, exp_s.ch, exp_s.sc, exp_s.to);
          end
        end
      end
      if (sweep_done)    n_done++;
      if (sweep_aborted) n_abort++;
      if (config_error)  n_cfgerr++;
      if (busy && (!prev_busy || ({ch, sc} != prev_cs))) stamp = cyc;
      if (zstart && !prev_zstart) begin
        hi_cnt = 0;
        if (chk_timing) begin
          vectors++;
          n_timing++;
          if (cyc - stamp !== 16) begin
            miscompares++;
            $display("FAIL settle_time: got %0d cycles, want 16", cyc - stamp);
          end
        end
      end
      if (zstart) hi_cnt++;
      if (!zstart && prev_zstart && chk_timing) begin
        vectors++;
        n_timing++;
        if (hi_cnt !== 40) begin
          miscompares++;
          $display("FAIL start_width: got %0d cycles, want 40", hi_cnt);
        end
      end
    end
    prev_zstart = zstart;
    prev_busy   = busy;
    prev_cs     = {ch, sc};
  end

  task automatic push_sweep(input int f, input int l, input logic [3:0] m);
    step_t s;
    for (int c = f; c <= l; c++)
      for (int k = 0; k < 4; k++)
        if (m[k]) begin
          s.ch = 12'(c);
          s.sc = 2'(k);
          s.to = 1'b0;
          sb_q.push_back(s);
        end
  endtask

  task automatic start_sweep(input int f, input int l, input logic [3:0] m);
    @(negedge clk);
    first_channel = 12'(f);
    last_channel  = 12'(l);
    scale_mask    = m;
    sweep_start   = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    vectors++;
    if ({busy, ch} !== {1'b1, 12'(f)}) begin
      miscompares++;
      $display("FAIL start_latch: got busy=%0b ch=%0d, want busy=1 ch=%0d", busy, ch, f);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: got busy=%0b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic wait_fall(input int budget, input string name);
    int n = 0;
    logic p = zstart;
    while (n < budget && !(p && !zstart)) begin
      p = zstart;
      @(negedge clk);
      n++;
    end
    if (!(p && !zstart)) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_fall: got no zcheck_start fall in %0d cycles, want one", name, budget);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    sweep_start = 0; sweep_abort = 0; first_channel = 0; last_channel = 0; scale_mask = 0;
    to_start = 0; to_abort = 0; to_done = 0; to_first = 0; to_last = 0; to_mask = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ch, sc, zstart, busy, step_valid, step_timeout, sweep_done, sweep_aborted,
         config_error, timeout_count} !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ch=%0d sc=%0d busy=%0b start=%0b tc=%0d, want all 0",
               ch, sc, busy, zstart, timeout_count);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_small_sweep();
    int d0 = n_done, s0 = n_steps;
    resp_en = 1'b1;
    resp_delay = 100;
    push_sweep(169, 171, 4'b1000);
    start_sweep(169, 171, 4'b1000);
    wait_idle(2000, "small");
    vectors++;
    if ((n_steps - s0) !== 3 || sb_q.size() !== 0) begin
      miscompares++;
      $display("FAIL small_steps: got %0d steps (%0d pending), want 3 (0)", n_steps - s0, sb_q.size());
    end
    vectors++;
    if ((n_done - d0) !== 1 || timeout_count !== 12'd0) begin
      miscompares++;
      $display("FAIL small_done: got done=%0d tc=%0d, want done=1 tc=0", n_done - d0, timeout_count);
    end
  endtask

  task automatic test_scale_order();
    int t0 = n_timing;
    resp_en = 1'b1;
    resp_delay = 10;
    chk_timing = 1'b1;
    push_sweep(5, 5, 4'b1011);
    start_sweep(5, 5, 4'b1011);
    wait_idle(1000, "scale");
    chk_timing = 1'b0;
    vectors++;
    if ((n_timing - t0) !== 6 || sb_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scale_steps: got %0d timing checks (%0d pending), want 6 (0)",
               n_timing - t0, sb_q.size());
    end
  endtask

  task automatic test_timeout();
    int n = 0, nd = 0, cnt = 0;
    logic p;
    @(negedge clk);
    to_first = 12'd0; to_last = 12'd1; to_mask = 4'b0001; to_start = 1'b1;
    @(negedge clk);
    to_start = 1'b0;
    while (to_busy && cnt < 500) begin
      if (to_step_valid) begin
        vectors++;
        if ({to_ch, to_step_timeout} !== {12'(n), 1'b1}) begin
          miscompares++;
          $display("FAIL timeout_step: got ch=%0d to=%0b, want ch=%0d to=1", to_ch, to_step_timeout, n);
        end
        n++;
      end
      if (to_sweep_done) nd++;
      @(negedge clk);
      cnt++;
    end
    vectors++;
    if (n !== 2 || nd !== 1 || to_tcount !== 12'd2 || to_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_sweep: got steps=%0d done=%0d tc=%0d busy=%0b, want 2 1 2 0",
               n, nd, to_tcount, to_busy);
    end
    // done on the very cycle the 50-cycle wait expires
    @(negedge clk);
    to_first = 12'd7; to_last = 12'd7; to_start = 1'b1;
    @(negedge clk);
    to_start = 1'b0;
    cnt = 0;
    p = to_zstart;
    while (cnt < 200 && !(p && !to_zstart)) begin
      p = to_zstart;
      @(negedge clk);
      cnt++;
    end
    repeat (49) @(negedge clk);
    to_done = 1'b1;
    @(negedge clk);
    to_done = 1'b0;
    vectors++;
    if ({to_step_valid, to_step_timeout, to_tcount} !== {1'b1, 1'b0, 12'd0}) begin
      miscompares++;
      $display("FAIL timeout_tie: got valid=%0b to=%0b tc=%0d, want 1 0 0",
               to_step_valid, to_step_timeout, to_tcount);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reject();
    int f_t[3] = '{10, 0, 0};
    int l_t[3] = '{9, 256, 3};
    logic [3:0] m_t[3] = '{4'b0001, 4'b0001, 4'b0000};
    logic [25:0] snap;
    int c0;
    resp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      snap = {ch, sc, timeout_count};
      c0 = n_cfgerr;
      @(negedge clk);
      first_channel = 12'(f_t[i]);
      last_channel  = 12'(l_t[i]);
      scale_mask    = m_t[i];
      sweep_start   = 1'b1;
      repeat (5) @(negedge clk);
      sweep_start = 1'b0;
      @(negedge clk);
      vectors++;
      if ((n_cfgerr - c0) !== 1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reject_%0d: got errs=%0d busy=%0b, want 1 0", i, n_cfgerr - c0, busy);
      end
      vectors++;
      if ({ch, sc, timeout_count} !== snap) begin
        miscompares++;
        $display("FAIL reject_hold_%0d: got %h, want %h", i, {ch, sc, timeout_count}, snap);
      end
    end
  endtask

  task automatic test_abort();
    int a0 = n_abort, d0 = n_done, s0 = n_steps, c0;
    resp_en = 1'b0;
    start_sweep(20, 30, 4'b0001);
    wait_fall(200, "abort");
    repeat (5) @(negedge clk);
    sweep_abort = 1'b1;
    @(negedge clk);
    sweep_abort = 1'b0;
    vectors++;
    if ({zstart, busy, sweep_aborted} !== 3'b001) begin
      miscompares++;
      $display("FAIL abort_wait: got start=%0b busy=%0b aborted=%0b, want 0 0 1", zstart, busy, sweep_aborted);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if ((n_abort - a0) !== 1 || n_done !== d0 || n_steps !== s0) begin
      miscompares++;
      $display("FAIL abort_counts: got aborts=%0d dones=%0d steps=%0d, want 1 0 0",
               n_abort - a0, n_done - d0, n_steps - s0);
    end
    a0 = n_abort;
    c0 = n_cfgerr;
    first_channel = 12'd0; last_channel = 12'd3; scale_mask = 4'b0001;
    sweep_start = 1'b1;
    sweep_abort = 1'b1;
    repeat (4) @(negedge clk);
    sweep_start = 1'b0;
    sweep_abort = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || zstart !== 1'b0 || n_abort !== a0 || n_cfgerr !== c0) begin
      miscompares++;
      $display("FAIL abort_start_idle: got busy=%0b start=%0b aborts=%0d errs=%0d, want 0 0 0 0",
               busy, zstart, n_abort - a0, n_cfgerr - c0);
    end
  endtask

  task automatic test_reset_mid_start();
    int s0, d0, cnt = 0;
    resp_en = 1'b1;
    resp_delay = 5;
    start_sweep(100, 101, 4'b0001);
    while (zstart !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({ch, sc, zstart, busy, step_valid, step_timeout, sweep_done, sweep_aborted,
         config_error, timeout_count} !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_mid_start: got ch=%0d start=%0b busy=%0b, want all 0", ch, zstart, busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    s0 = n_steps;
    d0 = n_done;
    push_sweep(240, 255, 4'b0001);
    start_sweep(240, 255, 4'b0001);
    wait_idle(3000, "post_reset");
    vectors++;
    if ((n_steps - s0) !== 16 || (n_done - d0) !== 1 || sb_q.size() !== 0) begin
      miscompares++;
      $display("FAIL post_reset_sweep: got steps=%0d done=%0d pending=%0d, want 16 1 0",
               n_steps - s0, n_done - d0, sb_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_small_sweep();
    test_scale_order();
    test_timeout();
    test_reject();
    test_abort();
    test_reset_mid_start();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
